// File: rtl/keypad_4x4_cntr.sv
// keypad_4x4_cntr: column-scanning 4x4 keypad reader with
// row synchroniser, tick-sampled debounce and press/hold reporting.
module keypad_4x4_cntr #(
   parameter int SCAN_CYCLES  = 100000,
   parameter int DEBOUNCE_CNT = 10
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_value,
   output logic       key_valid,
   output logic       key_held
);

   localparam int TW = $clog2(SCAN_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT);
   localparam bit INSTANT = (DEBOUNCE_CNT == 1);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [3:0]    row_m, row_s;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [DW-1:0] dcnt, dcnt_n, dcnt_inc;
   logic [1:0]    r, r_n, c, c_n;
   logic [1:0]    col_idx, row_idx;
   logic [3:0]    col_n, col_rot, kv_n;
   logic          valid_n, held_n, r_hit;

   assign tick     = (tcnt == T_LAST);
   assign col_rot  = {col[2:0], col[3]};
   assign dcnt_inc = dcnt + DW'(1);
   assign r_hit    = row_s[r];

   always_comb begin
      col_idx = 2'd0;
      unique case (1'b1)
         col[1]:  col_idx = 2'd1;
         col[2]:  col_idx = 2'd2;
         col[3]:  col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   // lowest active row wins when several rows are pressed
   always_comb begin
      row_idx = 2'd0;
      priority case (1'b1)
         row_s[0]: row_idx = 2'd0;
         row_s[1]: row_idx = 2'd1;
         row_s[2]: row_idx = 2'd2;
         row_s[3]: row_idx = 2'd3;
         default:  row_idx = 2'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         row_m <= '0;
         row_s <= '0;
         tcnt  <= '0;
      end else begin
         row_m <= row;
         row_s <= row_m;
         tcnt  <= tick ? '0 : tcnt + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state     <= SCAN;
         col       <= 4'b0001;
         r         <= 2'd0;
         c         <= 2'd0;
         dcnt      <= '0;
         key_value <= 4'd0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         state     <= state_n;
         col       <= col_n;
         r         <= r_n;
         c         <= c_n;
         dcnt      <= dcnt_n;
         key_value <= kv_n;
         key_valid <= valid_n;
         key_held  <= held_n;
      end
   end

   always_comb begin
      state_n = state;
      col_n   = col;
      r_n     = r;
      c_n     = c;
      dcnt_n  = dcnt;
      kv_n    = key_value;
      valid_n = 1'b0;
      held_n  = key_held;
      case (state)
         SCAN: begin
            if (tick) begin
               if (row_s == 4'd0) begin
                  col_n = col_rot;
               end else begin
                  r_n = row_idx;
                  c_n = col_idx;
                  if (INSTANT) begin
                     kv_n    = {row_idx, col_idx};
                     valid_n = 1'b1;
                     held_n  = 1'b1;
                     dcnt_n  = '0;
                     state_n = HOLD;
                  end else begin
                     dcnt_n  = DW'(1);
                     state_n = DEBOUNCE;
                  end
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (!r_hit) begin
                  col_n   = col_rot;
                  dcnt_n  = '0;
                  state_n = SCAN;
               end else if (dcnt_inc == D_LAST) begin
                  kv_n    = {r, c};
                  valid_n = 1'b1;
                  held_n  = 1'b1;
                  dcnt_n  = '0;
                  state_n = HOLD;
               end else begin
                  dcnt_n = dcnt_inc;
               end
            end
         end
         HOLD: begin
            // only the latched key matters until it is released
            if (tick) begin
               if (r_hit) begin
                  dcnt_n = '0;
               end else if (dcnt_inc == D_LAST) begin
                  held_n  = 1'b0;
                  col_n   = col_rot;
                  dcnt_n  = '0;
                  state_n = SCAN;
               end else begin
                  dcnt_n = dcnt_inc;
               end
            end
         end
         default: begin
            dcnt_n  = '0;
            held_n  = 1'b0;
            state_n = SCAN;
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_4x4_cntr.sv
// tb_keypad_4x4_cntr: keypad matrix model, vector tables and a
// scoreboard of expected key codes checked on every key_valid.
module tb_keypad_4x4_cntr;

   localparam int SC  = 4;
   localparam int DB  = 3;
   localparam int LAT = 12;

   logic       clk = 1'b0;
   logic       reset_p;
   logic [3:0] row, col, key_value;
   logic       key_valid, key_held;
   logic [3:0] keys [4];

   int cyc       = 0;
   int checks    = 0;
   int errors    = 0;
   int valid_cnt = 0;

   typedef struct {
      logic [3:0] code;
      int         at;
   } exp_t;

   typedef struct {
      int         at;
      logic [3:0] col;
      logic [1:0] vh;
   } scan_vec_t;

   typedef struct {
      int         r;
      int         c;
      int         hold;
      logic [3:0] code;
   } key_vec_t;

   exp_t      sb [$];
   exp_t      mon_e;
   scan_vec_t sv [8];
   key_vec_t  kt [3];

   keypad_4x4_cntr #(
      .SCAN_CYCLES (SC),
      .DEBOUNCE_CNT(DB)
   ) dut (
      .clk      (clk),
      .reset_p  (reset_p),
      .row      (row),
      .col      (col),
      .key_value(key_value),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      row = '0;
      for (int i = 0; i < 4; i++)
         row[i] = |(keys[i] & col);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic expect_key(input logic [3:0] code, input int at);
      exp_t e;
      e.code = code;
      e.at   = at;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (key_valid) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_code", key_value, mon_e.code);
            if (mon_e.at >= 0)
               chk("sb_cycle", cyc, mon_e.at);
         end
      end
   end

   task automatic wait_col(input logic [3:0] target);
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (col != target) break;
      end
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (col == target) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_col", ok, 1);
   endtask

   task automatic wait_held_low(output int n);
      n = 0;
      while (key_held && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int         k, v0, bad, lat;
      logic [3:0] ccol;
      bit         seen;

      sv[0] = '{1,  4'b0001, 2'b00};
      sv[1] = '{3,  4'b0001, 2'b00};
      sv[2] = '{4,  4'b0010, 2'b00};
      sv[3] = '{7,  4'b0010, 2'b00};
      sv[4] = '{8,  4'b0100, 2'b00};
      sv[5] = '{12, 4'b1000, 2'b00};
      sv[6] = '{15, 4'b1000, 2'b00};
      sv[7] = '{16, 4'b0001, 2'b00};
      kt[0] = '{2, 1, 40,  4'h9};
      kt[1] = '{0, 0, 200, 4'h0};
      kt[2] = '{3, 2, 16,  4'hE};

      for (int i = 0; i < 4; i++) keys[i] = '0;
      reset_p = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_col", col, 4'b0001);
      chk("rst_value", key_value, 0);
      chk("rst_valid", key_valid, 0);
      chk("rst_held", key_held, 0);
      reset_p = 1'b0;

      k = 0;
      foreach (sv[i]) begin
         while (k < sv[i].at) begin
            @(negedge clk);
            k++;
         end
         chk("scan_col", col, sv[i].col);
         chk("scan_vh", {key_valid, key_held}, sv[i].vh);
      end

      foreach (kt[i]) begin
         ccol = 4'b0001 << kt[i].c;
         wait_col(ccol);
         v0 = valid_cnt;
         keys[kt[i].r][kt[i].c] = 1'b1;
         expect_key(kt[i].code, cyc + LAT);
         bad = 0;
         repeat (kt[i].hold) begin
            @(negedge clk);
            if (col != ccol) bad++;
         end
         chk("key_col_frozen", bad, 0);
         chk("key_pulses", valid_cnt - v0, 1);
         chk("key_held_on", key_held, 1);
         chk("key_value", key_value, kt[i].code);
         keys[kt[i].r][kt[i].c] = 1'b0;
         wait_held_low(lat);
         chk("key_release_lat", lat, LAT);
         chk("key_col_next", col, {ccol[2:0], ccol[3]});
      end

      wait_col(4'b0001);
      v0 = valid_cnt;
      keys[1][0] = 1'b1;
      repeat (6) @(negedge clk);
      chk("glitch_freeze", col, 4'b0001);
      keys[1][0] = 1'b0;
      repeat (7) @(negedge clk);
      chk("glitch_resume", col, 4'b0010);
      repeat (20) @(negedge clk);
      chk("glitch_pulses", valid_cnt - v0, 0);
      chk("glitch_value", key_value, 4'hE);
      chk("glitch_held", key_held, 0);

      wait_col(4'b1000);
      keys[1][3] = 1'b1;
      keys[3][3] = 1'b1;
      expect_key(4'h7, cyc + LAT);
      repeat (16) @(negedge clk);
      chk("multi_value", key_value, 4'h7);
      chk("multi_held", key_held, 1);
      keys[1][3] = 1'b0;
      wait_held_low(lat);
      chk("multi_release_lat", lat, LAT);
      chk("multi_col_next", col, 4'b0001);
      expect_key(4'hF, -1);
      seen = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (key_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("row3_seen", seen, 1);
      chk("row3_value", key_value, 4'hF);
      keys[3][3] = 1'b0;
      wait_held_low(lat);
      chk("row3_release_lat", lat, LAT);

      wait_col(4'b0100);
      keys[2][2] = 1'b1;
      expect_key(4'hA, cyc + LAT);
      repeat (16) @(negedge clk);
      chk("pre_rst_held", key_held, 1);
      chk("pre_rst_value", key_value, 4'hA);
      reset_p = 1'b1;
      #1;
      chk("mid_rst_col", col, 4'b0001);
      chk("mid_rst_held", key_held, 0);
      chk("mid_rst_value", key_value, 0);
      chk("mid_rst_valid", key_valid, 0);
      repeat (3) @(negedge clk);
      reset_p = 1'b0;
      v0 = valid_cnt;
      expect_key(4'hA, cyc + 20);
      repeat (24) @(negedge clk);
      chk("redetect_pulses", valid_cnt - v0, 1);
      chk("redetect_held", key_held, 1);
      chk("redetect_value", key_value, 4'hA);
      keys[2][2] = 1'b0;
      wait_held_low(lat);
      chk("redetect_release", key_held, 0);

      repeat (4) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
